// File: rtl/serial_add_pkg.sv
// Shared definitions for the bit-serial adder controller: FSM state encoding
// and the default operand width.
package serial_add_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/serial_add_ctrl_fa_cell.sv
// Purely combinational 1-bit full adder, reused once per bit by the serial
// adder controller.
module fa_cell (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: feeds one full-adder cell LSB-first for WIDTH
// cycles and holds {cout,sum} until the next accepted request.
module serial_add_ctrl
    import serial_add_pkg::*;
#(
    parameter  int WIDTH = DEFAULT_WIDTH,
    localparam int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   aSr_q, aSr_d;
    logic [WIDTH-1:0]   bSr_q, bSr_d;
    logic [WIDTH-1:0]   sumSr_q, sumSr_d;
    logic               carry_q, carry_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   sum_q, sum_d;
    logic               cout_q, cout_d;

    logic               cellS;
    logic               cellCo;
    logic [WIDTH-1:0]   sumShift;

    fa_cell uFaCell (
        .a  (aSr_q[0]),
        .b  (bSr_q[0]),
        .ci (carry_q),
        .s  (cellS),
        .co (cellCo)
    );

    // New bit enters at the MSB so after WIDTH shifts bit 0 sits at the LSB.
    assign sumShift = {cellS, sumSr_q[WIDTH-1:1]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            aSr_q   <= '0;
            bSr_q   <= '0;
            sumSr_q <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            aSr_q   <= aSr_d;
            bSr_q   <= bSr_d;
            sumSr_q <= sumSr_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
        end
    end

    always_comb begin
        state_d = state_q;
        aSr_d   = aSr_q;
        bSr_d   = bSr_q;
        sumSr_d = sumSr_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        cout_d  = cout_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    aSr_d   = a;
                    bSr_d   = b;
                    carry_d = cin;
                    cnt_d   = '0;
                    sumSr_d = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                sumSr_d = sumShift;
                carry_d = cellCo;
                aSr_d   = aSr_q >> 1;
                bSr_d   = bSr_q >> 1;
                cnt_d   = cnt_q + CNT_W'(1);
                // Published outputs change only here, so they stay stable
                // through DONE and IDLE until the next operation finishes.
                if (cnt_q == LAST_BIT) begin
                    sum_d   = sumShift;
                    cout_d  = cellCo;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign busy = (state_q != ST_IDLE);
    assign done = (state_q == ST_DONE);
    assign sum  = sum_q;
    assign cout = cout_q;

endmodule
